tone_decoder: RTL and testbench
===============================

Name: tone_decoder

Overview:
- Receive-side counterpart of the PWM tone generator: measures the period of an incoming square-wave tone and decodes it to a note index.
- Input is the tone pin, or a loopback of the generator's pmod_1 for self-test.
- Outputs the raw period, a stable note code, and a silence flag; they feed state/pitch logic and the display.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; the note table is computed from it.
- CNT_W, 24, period counter width.
- MIN_PERIOD, 1000, edges closer than this many cycles are glitches.
- TIMEOUT_CYC, 2_000_000, cycles without a valid edge before declaring silence.
- STABLE_CNT, 3, consecutive identical decodes required to update the note.
- TOL_SHIFT, 6, match tolerance is ref_period >> TOL_SHIFT (about 1.56%).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tone_in  in  1  asynchronous square-wave tone
- period  out  CNT_W  last accepted period, in clk cycles
- period_valid  out  1  one-cycle pulse when period updates
- note  out  4  decoded note code (NOTE_NONE = 4'hF)
- note_valid  out  1  note holds a stable, matched code
- silent  out  1  no valid tone within TIMEOUT_CYC

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: period=0, period_valid=0, note=NOTE_NONE, note_valid=0, silent=1, FSM=IDLE, counters=0, candidate=NOTE_NONE.
- Input front end: 2-flop synchronizer on tone_in, then a registered rising-edge detect ("rise").
- cnt: increments every cycle and saturates at TIMEOUT_CYC. Cleared to 0 on every accepted rise.
- FSM IDLE: silent=1. The first rise clears cnt and moves to ARMED. silent stays 1.
- FSM ARMED/RUN, on each rise:
  - If cnt+1 < MIN_PERIOD: the edge is ignored and cnt keeps running.
  - Otherwise: period <= cnt+1, period_valid pulses in the next cycle, cnt <= 0, state <= RUN, silent <= 0.
- Timeout: in ARMED/RUN, when cnt reaches TIMEOUT_CYC-1 with no accepted rise:
  - Next cycle goes to IDLE with silent=1, note_valid=0, note=NOTE_NONE.
  - Stability counter and candidate are cleared.
- Match, one register stage after period_valid:
  - idx = first table entry i (0..7 = C4 D4 E4 F4 G4 A4 B4 C5) with |period - REF[i]| <= REF[i]>>TOL_SHIFT, else NOTE_NONE.
  - Subtraction is CNT_W+1 signed. REF[i] = round(CLK_HZ/f_i).
- Stability:
  - If idx == candidate: stab++ (saturates at STABLE_CNT). Otherwise candidate <= idx, stab <= 1.
  - When stab reaches STABLE_CNT: note <= candidate and note_valid <= (candidate != NOTE_NONE), the cycle after the match stage.
  - note holds until the next stable decision or timeout.
- Latency: note updates 2 cycles after the period_valid pulse of the STABLE_CNT-th matching period.
- Boundaries:
  - The first rise after IDLE never produces a period.
  - A rise coinciding with the timeout cycle counts as accepted (rise wins); no silence is declared.
  - period saturates at TIMEOUT_CYC.
  - reset mid-measurement discards the partial count.

Optional Feature:
- Macro TONE_DEC_AVG_EN.
- Defined: the match stage uses (period_prev + period) >> 1.
  - period_prev is cleared on entry to IDLE.
  - The first period after IDLE is matched unaveraged.
  - Adds one register and one adder; latency is unchanged.
- Undefined: each raw period is matched directly.

Decomposition:
- Package tone_dec_pkg:
  - note_t (4-bit) and NOTE_NONE.
  - Note frequency constants (centi-Hz).
  - Function ref_period(clk_hz, f) and the NUM_NOTES=8 table.
  - FSM state enum {IDLE, ARMED, RUN}.
- Sub-module tone_period_matcher: registered period -> idx lookup over the table, parameterized by CLK_HZ/TOL_SHIFT.
- Synchronizer, counter, FSM and stability filter stay in tone_decoder.

Test Plan:
- 440 Hz square (period 227,273 cycles) after reset -> silent falls at the 2nd rise; period=227273 each pulse; after the 4th rise, note=5 and note_valid=1.
- 523.25 Hz then switch to 261.63 Hz -> note stays 7 for 2 mismatched periods; becomes 0 on the 3rd consecutive C4 period (382,219).
- 300 Hz (333,333 cycles) -> idx NOTE_NONE; after 3 periods, note=4'hF and note_valid=0; silent=0.
- 440 Hz with a 10-cycle high glitch mid-period -> glitch edge ignored; period still 227273 ±1; note unchanged.
- Tone stops after note_valid -> exactly TIMEOUT_CYC=2,000,000 cycles after the last rise: silent=1, note_valid=0, note=4'hF.
- Reset asserted mid-period for 1 cycle -> all outputs return to reset values next cycle; the first post-reset rise gives no period_valid.

Source files
------------

// File: rtl/tone_dec_pkg.sv
// Shared types, note table and FSM states for the tone decoder.
package tone_dec_pkg;

    typedef logic [3:0] note_t;

    localparam note_t NOTE_NONE = 4'hF;
    localparam int    NUM_NOTES = 8;

    // C4 D4 E4 F4 G4 A4 B4 C5, in centi-Hz
    localparam int unsigned NOTE_CHZ [NUM_NOTES] = '{
        26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } dec_state_t;

    // Rounded period in clock cycles of a tone given in centi-Hz.
    function automatic longint unsigned ref_period(input longint unsigned clk_hz,
                                                   input longint unsigned f_chz);
        return (clk_hz * 100 + f_chz / 2) / f_chz;
    endfunction

endpackage

// File: rtl/tone_period_matcher.sv
// Registered lookup of a measured period against the note table; first entry within
// tolerance wins, otherwise NOTE_NONE.
module tone_period_matcher
    import tone_dec_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned TOL_SHIFT = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period_i,
    input  logic             valid_i,
    output note_t            idx_o,
    output logic             valid_o
);

    logic [NUM_NOTES-1:0] hit;
    note_t                idx_d;
    note_t                idx_q;
    logic                 valid_q;

    for (genvar g = 0; g < NUM_NOTES; g++) begin : g_note
        localparam logic [CNT_W-1:0] REF = CNT_W'(ref_period(64'(CLK_HZ), 64'(NOTE_CHZ[g])));
        localparam logic [CNT_W:0]   TOL = {1'b0, REF >> TOL_SHIFT};

        logic signed [CNT_W:0] diff;
        logic        [CNT_W:0] mag;

        assign diff   = $signed({1'b0, period_i}) - $signed({1'b0, REF});
        assign mag    = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        assign hit[g] = (mag <= TOL);
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        idx_d = NOTE_NONE;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx_d = note_t'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= NOTE_NONE;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                idx_q <= idx_d;
            end
        end
    end

    assign idx_o   = idx_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/tone_decoder.sv
// Measures the rising-edge period of an incoming tone and decodes it to a stable note code.
// Optional macro TONE_DEC_AVG_EN: match on the average of the previous and current period.
module tone_decoder
    import tone_dec_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned MIN_PERIOD  = 1000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned STABLE_CNT  = 3,
    parameter int unsigned TOL_SHIFT   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tone_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output note_t            note,
    output logic             note_valid,
    output logic             silent
);

    localparam int               STAB_W   = $clog2(STABLE_CNT + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);

    logic             sync1_q, sync2_q, sync3_q, rise_q;
    dec_state_t       state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_plus1;
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;
    logic             silent_q;
    logic             accept, to_fire;

    logic [CNT_W-1:0] match_in;
    note_t            match_idx;
    logic             match_vld;

    logic [STAB_W-1:0] stab_q, stab_d;
    note_t             cand_q, cand_d;
    note_t             note_q;
    logic              note_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            rise_q  <= sync2_q & ~sync3_q;
        end
    end

    assign cnt_plus1 = cnt_q + 1'b1;
    assign cnt_d     = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_plus1;
    assign accept    = (state_q != IDLE) && rise_q && (cnt_plus1 >= MIN_P);
    // An accepted rise on the last count beats the timeout.
    assign to_fire   = (state_q != IDLE) && !accept && (cnt_q >= CNT_TO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            silent_q       <= 1'b1;
        end else begin
            period_valid_q <= 1'b0;
            cnt_q          <= cnt_d;
            case (state_q)
                IDLE: begin
                    silent_q <= 1'b1;
                    if (rise_q) begin
                        cnt_q   <= '0;
                        state_q <= ARMED;
                    end
                end
                ARMED, RUN: begin
                    if (accept) begin
                        period_q       <= cnt_plus1;
                        period_valid_q <= 1'b1;
                        cnt_q          <= '0;
                        state_q        <= RUN;
                        silent_q       <= 1'b0;
                    end else if (to_fire) begin
                        state_q  <= IDLE;
                        silent_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TONE_DEC_AVG_EN
    logic [CNT_W-1:0] period_prev_q;
    logic             prev_vld_q;
    logic [CNT_W:0]   period_sum;

    assign period_sum = {1'b0, period_prev_q} + {1'b0, period_q};
    assign match_in   = prev_vld_q ? CNT_W'(period_sum >> 1) : period_q;

    always_ff @(posedge clk) begin
        if (reset || to_fire) begin
            period_prev_q <= '0;
            prev_vld_q    <= 1'b0;
        end else if (period_valid_q) begin
            period_prev_q <= period_q;
            prev_vld_q    <= 1'b1;
        end
    end
`else
    assign match_in = period_q;
`endif

    tone_period_matcher #(
        .CLK_HZ   (CLK_HZ),
        .CNT_W    (CNT_W),
        .TOL_SHIFT(TOL_SHIFT)
    ) u_matcher (
        .clk     (clk),
        .reset   (reset),
        .period_i(match_in),
        .valid_i (period_valid_q),
        .idx_o   (match_idx),
        .valid_o (match_vld)
    );

    always_comb begin
        stab_d = stab_q;
        cand_d = cand_q;
        if (match_vld) begin
            if (match_idx == cand_q) begin
                stab_d = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 1'b1;
            end else begin
                cand_d = match_idx;
                stab_d = STAB_W'(1);
            end
        end
    end

    // The note is committed in the same cycle the run length reaches its target.
    always_ff @(posedge clk) begin
        if (reset || to_fire) begin
            stab_q       <= '0;
            cand_q       <= NOTE_NONE;
            note_q       <= NOTE_NONE;
            note_valid_q <= 1'b0;
        end else begin
            stab_q <= stab_d;
            cand_q <= cand_d;
            if (match_vld && (stab_d == STAB_MAX)) begin
                note_q       <= cand_d;
                note_valid_q <= (cand_d != NOTE_NONE);
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign note         = note_q;
    assign note_valid   = note_valid_q;
    assign silent       = silent_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with a scaled-down clock so notes span a few hundred cycles.
module tb_tone_decoder;

    localparam int CLK_HZ      = 200_000;
    localparam int CNT_W       = 24;
    localparam int MIN_PERIOD  = 100;
    localparam int TIMEOUT_CYC = 2000;
    localparam int STABLE_CNT  = 3;
    localparam int TOL_SHIFT   = 6;
    localparam logic [3:0] NONE = 4'hF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tone_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [3:0]       note;
    logic             note_valid;
    logic             silent;

    tone_decoder #(
        .CLK_HZ     (CLK_HZ),
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_PERIOD),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .STABLE_CNT (STABLE_CNT),
        .TOL_SHIFT  (TOL_SHIFT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tone_in     (tone_in),
        .period      (period),
        .period_valid(period_valid),
        .note        (note),
        .note_valid  (note_valid),
        .silent      (silent)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    real note_hz [8] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25};
    int  ref_tbl [8];

    typedef struct {
        int unsigned period;
        logic [3:0]  nb;
        logic        vb;
        logic [3:0]  na;
        logic        va;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  m_hist[$];
    bit          m_active;
    int unsigned m_last;
    logic [3:0]  m_note;
    logic        m_nv;
    int          m_prev;
    bit          m_prev_vld;

    function automatic logic [3:0] decode(input int p);
        for (int i = 0; i < 8; i++) begin
            int d = p - ref_tbl[i];
            if (d < 0) d = -d;
            if (d <= (ref_tbl[i] >> TOL_SHIFT)) return 4'(i);
        end
        return NONE;
    endfunction

    task automatic model_go_idle();
        m_active   = 1'b0;
        m_hist.delete();
        m_note     = NONE;
        m_nv       = 1'b0;
        m_prev     = 0;
        m_prev_vld = 1'b0;
    endtask

    task automatic model_rise(input int unsigned t);
        int unsigned d;
        int          mp;
        logic [3:0]  idx;
        exp_t        e;
        bit          stable;
        if (m_active && (t - m_last) > TIMEOUT_CYC) model_go_idle();
        if (!m_active) begin
            m_active = 1'b1;
            m_last   = t;
            return;
        end
        d = t - m_last;
        if (d < MIN_PERIOD) return;
        m_last = t;
        mp = int'(d);
`ifdef TONE_DEC_AVG_EN
        if (m_prev_vld) mp = (m_prev + int'(d)) / 2;
        m_prev     = int'(d);
        m_prev_vld = 1'b1;
`endif
        idx = decode(mp);
        m_hist.push_back(idx);
        e.period = d;
        e.nb     = m_note;
        e.vb     = m_nv;
        stable = (m_hist.size() >= STABLE_CNT);
        for (int i = 1; i <= STABLE_CNT && stable; i++) begin
            if (m_hist[m_hist.size() - i] != idx) stable = 1'b0;
        end
        if (stable) begin
            m_note = idx;
            m_nv   = (idx != NONE);
        end
        e.na = m_note;
        e.va = m_nv;
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic hold(input bit v, input int n);
        if (v && !tone_in) model_rise(cyc);
        tone_in = v;
        repeat (n) @(negedge clk);
    endtask

    // One period starting with a rise; g>0 inserts a 10-cycle dip whose rise lands g cycles in.
    task automatic one_period(input int p, input int g);
        if (g > 0) begin
            hold(1'b1, g - 10);
            hold(1'b0, 10);
            hold(1'b1, p / 2 - g);
        end else begin
            hold(1'b1, p / 2);
        end
        hold(1'b0, p - p / 2);
    endtask

    task automatic square(input int p, input int n);
        for (int i = 0; i < n; i++) one_period(p, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_period"}, period, 0);
        check_eq({tag, "_pv"}, period_valid, 0);
        check_eq({tag, "_note"}, note, NONE);
        check_eq({tag, "_nv"}, note_valid, 0);
        check_eq({tag, "_silent"}, silent, 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && period_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_period_valid", period_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("period", period, e.period);
                    check_eq("silent_on_period", silent, 0);
                    @(negedge clk);
                    check_eq("pv_one_cycle", period_valid, 0);
                    check_eq("note_hold", note, e.nb);
                    check_eq("nv_hold", note_valid, e.vb);
                    @(negedge clk);
                    check_eq("note", note, e.na);
                    check_eq("note_valid", note_valid, e.va);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (95_000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int a4, c4, c5, p, g, gaps;
        for (int i = 0; i < 8; i++) ref_tbl[i] = $rtoi(real'(CLK_HZ) / note_hz[i] + 0.5);
        a4 = ref_tbl[5];
        c4 = ref_tbl[0];
        c5 = ref_tbl[7];
        model_go_idle();

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // A4 from silence: first rise only arms
        square(a4, 1);
        check_eq("silent_after_first_rise", silent, 1);
        check_eq("no_period_after_first_rise", period, 0);
        square(a4, 4);
        check_eq("a4_note", note, 5);
        check_eq("a4_nv", note_valid, 1);

        // C5 then C4: note switches only on the third consecutive C4 period
        square(c5, 5);
        check_eq("c5_note", note, 7);
        square(c4, 3);
        check_eq("c4_two_periods_note", note, 7);
        square(c4, 1);
        check_eq("c4_note", note, 0);

        // off-table tone
        p = $rtoi(real'(CLK_HZ) / 300.0 + 0.5);
        square(p, 4);
        check_eq("offtable_note", note, NONE);
        check_eq("offtable_nv", note_valid, 0);
        check_eq("offtable_silent", silent, 0);

        // A4 with short glitches
        square(a4, 4);
        one_period(a4, 30);
        one_period(a4, 50);
        square(a4, 1);
        check_eq("glitch_note", note, 5);
        check_eq("glitch_nv", note_valid, 1);

        // MIN_PERIOD boundary: exactly MIN accepted, MIN-1 spacing skipped
        square(MIN_PERIOD, 3);
        square(MIN_PERIOD - 1, 4);

        // timeout boundary: gap of exactly TIMEOUT accepted, TIMEOUT+1 goes silent
        hold(1'b0, 200);
        hold(1'b1, 10);
        hold(1'b0, TIMEOUT_CYC - 10);
        hold(1'b1, 10);
        hold(1'b0, TIMEOUT_CYC + 1 - 10);
        hold(1'b1, 10);
        hold(1'b0, 480);
        check_eq("silent_after_timeout", silent, 1);
        check_eq("period_saturated", period, TIMEOUT_CYC);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 50);
        check_eq("silent_after_rearm", silent, 0);

        // tone stops after a valid note
        hold(1'b0, 500);
        square(a4, 4);
        check_eq("stop_note_before", note_valid, 1);
        hold(1'b1, a4 / 2);
        hold(1'b0, TIMEOUT_CYC - 4 - a4 / 2);
        check_eq("stop_silent_early", silent, 0);
        check_eq("stop_nv_early", note_valid, 1);
        hold(1'b0, 10);
        check_eq("stop_silent", silent, 1);
        check_eq("stop_nv", note_valid, 0);
        check_eq("stop_note", note, NONE);

        // reset pulse mid-period
        square(a4, 3);
        hold(1'b1, a4 / 2);
        hold(1'b0, 100);
        check_eq("pre_reset_note", note, 5);
        check_eq("pre_reset_drained", exp_q.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        reset = 1'b0;
        model_go_idle();
        hold(1'b0, 200);
        square(a4, 1);
        check_eq("post_reset_silent", silent, 1);
        check_eq("post_reset_period", period, 0);
        square(a4, 4);
        check_eq("post_reset_note", note, 5);

        // randomized segments
        gaps = 0;
        for (int s = 0; s < 20; s++) begin
            int kind = int'($urandom_range(0, 9));
            int n    = int'($urandom_range(1, 4));
            if (kind < 6) begin
                int k = int'($urandom_range(0, 7));
                for (int i = 0; i < n; i++) begin
                    p = ref_tbl[k] + int'($urandom_range(0, 4)) - 2;
                    g = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 110)) : 0;
                    one_period(p, g);
                end
            end else if (kind < 9 || gaps >= 2) begin
                for (int i = 0; i < n; i++) begin
                    p = int'($urandom_range(150, 1200));
                    g = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 72)) : 0;
                    one_period(p, g);
                end
            end else begin
                gaps++;
                hold(1'b0, TIMEOUT_CYC + int'($urandom_range(1, 200)));
            end
        end

        repeat (10) @(negedge clk);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
